freq_sort: RTL and testbench

- Stage directly downstream of the symbol-frequency counter in the Huffman encoder.
- Captures the 10-entry {frequency, symbol} table when counting finishes.
- Sorts the table by ascending frequency with an odd-even transposition network.
- Presents the sorted table and a done flag to the Huffman tree builder.

---
 rtl/freq_sort.sv | 132 +++++++++++++
 tb/tb_freq_sort.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/freq_sort.sv
// Sorts the 10-entry {freq, sym} table from the symbol counter by ascending key using odd-even transposition.
// Optional macro FREQ_SORT_ZERO_LAST_EN: zero-frequency entries sort last, and NZ_CNT reports the nonzero entries.
module freq_sort #(
    parameter int N  = 10,
    parameter int FW = 8,
    parameter int SW = 5
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   count_over,
    input  logic [N*(FW+SW)-1:0]   FREQUENT_IN,
    output logic [N*(FW+SW)-1:0]   SORTED_OUT,
    output logic                   sort_over,
    output logic [3:0]             NZ_CNT
);

    localparam int EW = FW + SW;
    localparam int PW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SORT = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_d;
    logic [EW-1:0]   arr    [N];
    logic [EW-1:0]   arr_nx [N];
    logic [PW-1:0]   pass;
    logic            cnt_q;
    logic            start;
    logic            last_pass;

    // Handshake: a rising edge of the count_over level starts one sort. sort_over then stays high
    // while SORTED_OUT is valid, and it drops one edge after count_over is seen low.
    assign start     = count_over & ~cnt_q;
    assign last_pass = (pass == PW'(N - 1));

    // A leading "is zero" bit pushes empty entries above every nonzero key when the feature is enabled.
    function automatic logic [EW:0] key_of(input logic [EW-1:0] e);
`ifdef FREQ_SORT_ZERO_LAST_EN
        key_of = {(e[EW-1:SW] == '0), e};
`else
        key_of = {1'b0, e};
`endif
    endfunction

    always_comb begin
        for (int k = 0; k < N; k++) arr_nx[k] = arr[k];
        if (!pass[0]) begin
            for (int i = 0; i < N / 2; i++) begin
                if (key_of(arr[2*i]) > key_of(arr[2*i+1])) begin
                    arr_nx[2*i]   = arr[2*i+1];
                    arr_nx[2*i+1] = arr[2*i];
                end
            end
        end else begin
            for (int i = 0; i < N / 2 - 1; i++) begin
                if (key_of(arr[2*i+1]) > key_of(arr[2*i+2])) begin
                    arr_nx[2*i+1] = arr[2*i+2];
                    arr_nx[2*i+2] = arr[2*i+1];
                end
            end
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (start) state_d = SORT;
            SORT:    if (last_pass) state_d = DONE;
            DONE:    if (sort_over && !count_over) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q      <= 1'b0;
            pass       <= '0;
            sort_over  <= 1'b0;
            SORTED_OUT <= '0;
            for (int k = 0; k < N; k++) arr[k] <= '0;
        end else begin
            cnt_q <= count_over;
            case (state)
                IDLE: begin
                    if (start) begin
                        for (int k = 0; k < N; k++) arr[k] <= FREQUENT_IN[k*EW +: EW];
                        pass <= '0;
                    end
                end
                SORT: begin
                    for (int k = 0; k < N; k++) arr[k] <= arr_nx[k];
                    pass <= pass + PW'(1);
                end
                DONE: begin
                    // First DONE edge publishes; later edges only watch for count_over to fall.
                    if (!sort_over) begin
                        for (int k = 0; k < N; k++) SORTED_OUT[k*EW +: EW] <= arr[k];
                        sort_over <= 1'b1;
                    end else if (!count_over) begin
                        sort_over <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FREQ_SORT_ZERO_LAST_EN
    logic [3:0] nz_sum;

    always_comb begin
        nz_sum = 4'd0;
        for (int k = 0; k < N; k++) nz_sum = nz_sum + 4'(arr[k][EW-1:SW] != '0);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)                          NZ_CNT <= 4'd0;
        else if (state == DONE && !sort_over) NZ_CNT <= nz_sum;
    end
`else
    assign NZ_CNT = 4'd0;
`endif

endmodule

// File: tb/tb_freq_sort.sv
// Directed bench for freq_sort: hand-ordered expected tables are queued, and a monitor compares them when sort_over rises.
module tb_freq_sort;

    localparam int N  = 10;
    localparam int EW = 13;
    localparam int W  = N * EW + 4;
`ifdef FREQ_SORT_ZERO_LAST_EN
    localparam bit ZL = 1'b1;
`else
    localparam bit ZL = 1'b0;
`endif

    logic              CLK = 1'b0;
    logic              RST;
    logic              count_over;
    logic [N*EW-1:0]   FREQUENT_IN;
    logic [N*EW-1:0]   SORTED_OUT;
    logic              sort_over;
    logic [3:0]        NZ_CNT;

    int                checks = 0;
    int                errors = 0;
    logic [W-1:0]      exp_q[$];
    logic [W-1:0]      last_exp;
    int                vf [N];
    int                es [N];
    logic              so_prev = 1'b0;

    freq_sort dut (
        .CLK         (CLK),
        .RST         (RST),
        .count_over  (count_over),
        .FREQUENT_IN (FREQUENT_IN),
        .SORTED_OUT  (SORTED_OUT),
        .sort_over   (sort_over),
        .NZ_CNT      (NZ_CNT)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [N*EW-1:0] pack_in();
        logic [N*EW-1:0] v;
        for (int k = 0; k < N; k++) v[k*EW +: EW] = {8'(vf[k]), 5'(k)};
        return v;
    endfunction

    function automatic logic [W-1:0] pack_exp(input int nz);
        logic [W-1:0] v;
        v[N*EW +: 4] = 4'(nz);
        for (int j = 0; j < N; j++) v[j*EW +: EW] = {8'(vf[es[j]]), 5'(es[j])};
        return v;
    endfunction

    // ---------------- driver ----------------
    task automatic start_sort(input string name, input bit pulse, input int nz);
        int lat;
        last_exp = pack_exp(nz);
        exp_q.push_back(last_exp);
        FREQUENT_IN = pack_in();
        count_over  = 1'b1;
        tick();                       // capture edge T
        if (pulse) count_over = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (sort_over) begin
                lat = c;
                break;
            end
        end
        check({name, "_latency"}, W'(lat), W'(N + 1));
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge CLK) begin
        if (RST) begin
            so_prev = 1'b0;
        end else begin
            if (sort_over && !so_prev) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_result actual=%h required=none", {NZ_CNT, SORTED_OUT});
                end else begin
                    check("result", {NZ_CNT, SORTED_OUT}, exp_q.pop_front());
                end
            end
            so_prev = sort_over;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        RST         = 1'b1;
        count_over  = 1'b0;
        FREQUENT_IN = '0;
        repeat (3) tick();
        check("reset_outputs", {NZ_CNT, SORTED_OUT}, '0);
        check("reset_sort_over", W'(sort_over), '0);
        RST = 1'b0;
        repeat (2) tick();

        // descending frequencies, short pulse
        vf = '{10, 9, 8, 7, 6, 5, 4, 3, 2, 1};
        es = '{9, 8, 7, 6, 5, 4, 3, 2, 1, 0};
        start_sort("descending", 1'b1, ZL ? 10 : 0);
        tick();
        check("descending_one_cycle", W'(sort_over), '0);

        // all equal: order must be untouched
        vf = '{7, 7, 7, 7, 7, 7, 7, 7, 7, 7};
        es = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
        start_sort("all_equal", 1'b1, ZL ? 10 : 0);
        tick();
        check("all_equal_one_cycle", W'(sort_over), '0);

        // mixed with ties and zeros
        vf = '{3, 1, 3, 0, 5, 1, 0, 2, 9, 4};
`ifdef FREQ_SORT_ZERO_LAST_EN
        es = '{1, 5, 7, 0, 2, 9, 4, 8, 3, 6};
`else
        es = '{3, 6, 1, 5, 7, 0, 2, 9, 4, 8};
`endif
        start_sort("mixed", 1'b1, ZL ? 8 : 0);
        tick();
        check("mixed_one_cycle", W'(sort_over), '0);

        // reset in the middle of a sort, released with count_over still high
        vf = '{1, 4, 7, 3, 6, 2, 5, 1, 4, 7};
        es = '{0, 7, 5, 3, 1, 8, 6, 4, 2, 9};
        FREQUENT_IN = pack_in();
        count_over  = 1'b1;
        tick();
        repeat (4) tick();
        RST = 1'b1;
        #1;
        check("midsort_reset_outputs", {NZ_CNT, SORTED_OUT}, '0);
        check("midsort_reset_sort_over", W'(sort_over), '0);
        repeat (2) tick();
        RST = 1'b0;
        start_sort("reset_recover", 1'b0, ZL ? 10 : 0);

        // count_over held: result stays put, no re-sort
        for (int i = 0; i < 20; i++) begin
            tick();
            check("hold_sort_over", W'(sort_over), W'(1));
            check("hold_outputs", {NZ_CNT, SORTED_OUT}, last_exp);
        end
        count_over = 1'b0;
        tick();
        check("drop_sort_over", W'(sort_over), '0);
        check("drop_outputs_kept", {NZ_CNT, SORTED_OUT}, last_exp);

        // re-arm with new data
        vf = '{3, 1, 3, 0, 5, 1, 0, 2, 9, 4};
`ifdef FREQ_SORT_ZERO_LAST_EN
        es = '{1, 5, 7, 0, 2, 9, 4, 8, 3, 6};
`else
        es = '{3, 6, 1, 5, 7, 0, 2, 9, 4, 8};
`endif
        start_sort("rearm", 1'b1, ZL ? 8 : 0);
        tick();
        check("rearm_one_cycle", W'(sort_over), '0);

        repeat (3) tick();
        check("queue_empty", W'(exp_q.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
